// File: rtl/axis_readout_sequencer.sv
// axis_readout_sequencer: drains N AXI-Stream sources in ascending index order into one DMA stream.
// Define AXIS_READOUT_TRAILER_EN to append a {source index, beat count} trailer word after each source.
module axis_readout_sequencer #(
    parameter int N_SOURCES   = 2,
    parameter int DWIDTH      = 128,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_SOURCES*DWIDTH-1:0]  data_in_data,
    input  logic [N_SOURCES-1:0]         data_in_valid,
    input  logic [N_SOURCES-1:0]         data_in_last,
    output logic [N_SOURCES-1:0]         data_in_ready,
    output logic [DWIDTH-1:0]            data_out_data,
    output logic                         data_out_valid,
    output logic                         data_out_last,
    input  logic                         data_out_ready,
    input  logic [N_SOURCES-1:0]         source_mask_data,
    input  logic                         source_mask_valid,
    output logic                         source_mask_ready,
    output logic                         busy,
    output logic [$clog2(N_SOURCES)-1:0] current_source
);
    localparam int SW = $clog2(N_SOURCES);

`ifdef AXIS_READOUT_TRAILER_EN
    typedef enum logic [1:0] {IDLE, STREAM, TRAILER} state_t;
`else
    typedef enum logic [1:0] {IDLE, STREAM} state_t;
`endif

    state_t                 state, state_n;
    logic [N_SOURCES-1:0]   mask, mask_n, above;
    logic [SW-1:0]          sel, sel_n, first_sel, next_sel;
    logic [COUNT_WIDTH-1:0] count, count_n;
    logic [DWIDTH-1:0]      src_data;
    logic                   src_valid, src_last, final_src;

    assign src_data       = data_in_data[sel*DWIDTH +: DWIDTH];
    assign src_valid      = data_in_valid[sel];
    assign src_last       = data_in_last[sel];
    assign final_src      = ~|above;
    assign busy           = state != IDLE;
    assign current_source = sel;

    // priority encoders: lowest bit of an incoming mask, and next enabled source above sel
    always_comb begin
        first_sel = '0;
        next_sel  = '0;
        above     = '0;
        for (int i = N_SOURCES - 1; i >= 0; i--) begin
            above[i] = mask[i] && (i > int'(sel));
            if (source_mask_data[i]) first_sel = SW'(i);
        end
        for (int i = N_SOURCES - 1; i >= 0; i--)
            if (above[i]) next_sel = SW'(i);
    end

    // next-state and output decode; the selected source is routed straight through in STREAM
    always_comb begin
        state_n           = state;
        mask_n            = mask;
        sel_n             = sel;
        count_n           = count;
        data_in_ready     = '0;
        data_out_data     = '0;
        data_out_valid    = 1'b0;
        data_out_last     = 1'b0;
        source_mask_ready = 1'b0;
        case (state)
            IDLE: begin
                source_mask_ready = 1'b1;
                if (source_mask_valid && |source_mask_data) begin
                    state_n = STREAM;
                    mask_n  = source_mask_data;
                    sel_n   = first_sel;
                    count_n = '0;
                end
            end
            STREAM: begin
                data_out_data       = src_data;
                data_out_valid      = src_valid;
                data_in_ready[sel]  = data_out_ready;
`ifdef AXIS_READOUT_TRAILER_EN
                data_out_last       = 1'b0;
`else
                data_out_last       = src_last && final_src;
`endif
                if (src_valid && data_out_ready) begin
                    count_n = &count ? count : count + 1'b1;
                    if (src_last) begin
`ifdef AXIS_READOUT_TRAILER_EN
                        state_n = TRAILER;
`else
                        state_n = final_src ? IDLE : STREAM;
                        sel_n   = final_src ? '0 : next_sel;
                        count_n = '0;
`endif
                    end
                end
            end
`ifdef AXIS_READOUT_TRAILER_EN
            TRAILER: begin
                data_out_valid = 1'b1;
                data_out_data  = DWIDTH'({sel, count});
                data_out_last  = final_src;
                if (data_out_ready) begin
                    state_n = final_src ? IDLE : STREAM;
                    sel_n   = final_src ? '0 : next_sel;
                    count_n = '0;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // state, latched mask, selected source and beat counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mask  <= '0;
            sel   <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            mask  <= mask_n;
            sel   <= sel_n;
            count <= count_n;
        end
    end
endmodule
